// File: rtl/video_pkg.sv
// Constants and controller state shared by the line-delay bank, its sequencer and the 5-tap cascade.
// Pure declarations; no logic, no latency, no flow control.
package video_pkg;

    localparam int VID_ADDR_W    = 11;
    localparam int VID_NUM_LINES = 4;
    localparam int VID_LINE_W    = 12;

    // Sync side-band delay = sequencer register + BRAM read + one stage per tap.
    localparam int CONV_TAPS = 5;
    localparam int CTRL_LAT  = 1;
    localparam int BRAM_LAT  = 1;
    localparam int PIPE_LAT  = CTRL_LAT + BRAM_LAT + CONV_TAPS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HBLANK = 2'd1,
        ST_ACTIVE = 2'd2
    } lb_state_t;

    function automatic int bank_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_det.sv
// 1-bit rise/fall detector: input registered once, edges compare live input against that register.
// Edges are combinational off the current input (0 cycles); no backpressure.
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/line_buf_ctrl.sv
// Line-delay bank sequencer: column address, write strobe, bank rotation and line/frame status.
// All outputs registered, 1 cycle after rx_dv/rx_vs; free-running, no backpressure.
module line_buf_ctrl
    import video_pkg::*;
#(
    parameter int  ADDR_W    = VID_ADDR_W,
    parameter int  NUM_LINES = VID_NUM_LINES,
    parameter int  LINE_W    = VID_LINE_W,
    localparam int BANK_W    = bank_width(NUM_LINES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_dv,
    input  logic              rx_hs,
    input  logic              rx_vs,
    output logic              wr_en,
    output logic [ADDR_W-1:0] col_addr,
    output logic [BANK_W-1:0] wr_bank,
    output logic [ADDR_W:0]   line_len,
    output logic [LINE_W-1:0] line_cnt,
    output logic              frame_start,
    output logic              filt_valid,
    output logic              first_col,
    output logic              last_col,
    output logic              len_err,
    output logic              ovf,
    output logic              hs_q
);

    localparam int LEN_W  = ADDR_W + 1;
    localparam int FILL_W = $clog2(NUM_LINES + 1);

    localparam logic [ADDR_W-1:0] COL_MAX   = '1;
    localparam logic [LINE_W-1:0] CNT_MAX   = '1;
    localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_LINES - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(NUM_LINES);

    lb_state_t         state;
    logic [FILL_W-1:0] lines_filled;
    logic              dv_rise;
    logic              dv_fall;
    logic              vs_rise;
    logic              vs_fall_unused;
    logic [LEN_W-1:0]  col_inc;
    logic              next_is_last;
    logic              bank_full;

    edge_det u_dv_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (rx_dv),
        .rise (dv_rise),
        .fall (dv_fall)
    );

    edge_det u_vs_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (rx_vs),
        .rise (vs_rise),
        .fall (vs_fall_unused)
    );

    // col_inc doubles as the pixel count at line end: a saturated column reads back as 2^ADDR_W.
    assign col_inc      = {1'b0, col_addr} + LEN_W'(1);
    assign next_is_last = (line_len != '0) && (col_inc == line_len - LEN_W'(1));
    assign bank_full    = (lines_filled == FILL_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            wr_en        <= 1'b0;
            col_addr     <= '0;
            wr_bank      <= '0;
            line_len     <= '0;
            line_cnt     <= '0;
            lines_filled <= '0;
            frame_start  <= 1'b0;
            filt_valid   <= 1'b0;
            first_col    <= 1'b0;
            last_col     <= 1'b0;
            len_err      <= 1'b0;
            ovf          <= 1'b0;
            hs_q         <= 1'b0;
        end else begin
            hs_q        <= rx_hs;
            frame_start <= 1'b0;
            wr_en       <= 1'b0;
            filt_valid  <= 1'b0;
            first_col   <= 1'b0;
            last_col    <= 1'b0;

            // Frame start overrides everything, including a coincident line end.
            if (vs_rise) begin
                state        <= ST_HBLANK;
                frame_start  <= 1'b1;
                col_addr     <= '0;
                wr_bank      <= '0;
                line_cnt     <= '0;
                lines_filled <= '0;
                len_err      <= 1'b0;
                ovf          <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end

                    ST_HBLANK: begin
                        if (dv_rise) begin
                            state      <= ST_ACTIVE;
                            wr_en      <= 1'b1;
                            col_addr   <= '0;
                            first_col  <= 1'b1;
                            last_col   <= (line_len == LEN_W'(1));
                            filt_valid <= bank_full;
                        end
                    end

                    ST_ACTIVE: begin
                        if (dv_fall) begin
                            state    <= ST_HBLANK;
                            col_addr <= '0;
                            line_len <= col_inc;
                            if ((line_len != '0) && (line_len != col_inc)) begin
                                len_err <= 1'b1;
                            end
                            wr_bank      <= (wr_bank == BANK_LAST) ? '0 : wr_bank + BANK_W'(1);
                            line_cnt     <= (line_cnt == CNT_MAX) ? line_cnt : line_cnt + LINE_W'(1);
                            lines_filled <= bank_full ? lines_filled : lines_filled + FILL_W'(1);
                        end else if (col_addr == COL_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            wr_en      <= 1'b1;
                            col_addr   <= col_addr + ADDR_W'(1);
                            last_col   <= next_is_last;
                            filt_valid <= bank_full;
                        end
                    end

                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: a default build and an ADDR_W=3 build share stimulus and are checked
// against a pixel-counting reference model plus directed expectations.
module tb_line_buf_ctrl;

    logic clk;
    logic rst;
    logic rx_dv;
    logic rx_hs;
    logic rx_vs;

    logic        wr_en, frame_start, filt_valid, first_col, last_col, len_err, ovf, hs_q;
    logic [10:0] col_addr;
    logic [1:0]  wr_bank;
    logic [11:0] line_len;
    logic [11:0] line_cnt;

    logic        wr_en_s, frame_start_s, filt_valid_s, first_col_s, last_col_s, len_err_s, ovf_s, hs_q_s;
    logic [2:0]  col_addr_s;
    logic [1:0]  wr_bank_s;
    logic [3:0]  line_len_s;
    logic [11:0] line_cnt_s;

    int vectors = 0;
    int miscompares = 0;

    line_buf_ctrl dut (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .wr_en(wr_en), .col_addr(col_addr), .wr_bank(wr_bank), .line_len(line_len),
        .line_cnt(line_cnt), .frame_start(frame_start), .filt_valid(filt_valid),
        .first_col(first_col), .last_col(last_col), .len_err(len_err), .ovf(ovf), .hs_q(hs_q)
    );

    line_buf_ctrl #(.ADDR_W(3)) dut_s (
        .clk(clk), .rst(rst), .rx_dv(rx_dv), .rx_hs(rx_hs), .rx_vs(rx_vs),
        .wr_en(wr_en_s), .col_addr(col_addr_s), .wr_bank(wr_bank_s), .line_len(line_len_s),
        .line_cnt(line_cnt_s), .frame_start(frame_start_s), .filt_valid(filt_valid_s),
        .first_col(first_col_s), .last_col(last_col_s), .len_err(len_err_s), .ovf(ovf_s), .hs_q(hs_q_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: frame/line bookkeeping in plain integers, one entry per build.
    int amax[2] = '{2048, 8};
    int m_started[2], m_inline[2], m_pix[2], m_lines[2], m_filled[2], m_bank[2];
    int m_len[2], m_col[2];
    bit m_lerr[2], m_ovf[2], m_wr[2], m_fs[2];
    bit m_hsq, m_dvp, m_vsp;

    task automatic model_step();
        bit vs_rise, dv_rise;
        int n;
        vs_rise = rx_vs && !m_vsp;
        dv_rise = rx_dv && !m_dvp;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_started[i] = 0; m_inline[i] = 0; m_pix[i] = 0; m_lines[i] = 0;
                m_filled[i] = 0; m_bank[i] = 0; m_len[i] = 0; m_col[i] = 0;
                m_lerr[i] = 0; m_ovf[i] = 0; m_wr[i] = 0; m_fs[i] = 0;
            end else begin
                m_fs[i] = 0;
                m_wr[i] = 0;
                if (vs_rise) begin
                    m_fs[i] = 1; m_started[i] = 1; m_inline[i] = 0; m_lines[i] = 0;
                    m_filled[i] = 0; m_bank[i] = 0; m_lerr[i] = 0; m_ovf[i] = 0; m_col[i] = 0;
                end else if (m_started[i] == 0) begin
                    m_wr[i] = 0;
                end else if (m_inline[i] != 0) begin
                    if (rx_dv) begin
                        m_pix[i]++;
                        if (m_pix[i] <= amax[i]) begin
                            m_col[i] = m_pix[i] - 1;
                            m_wr[i] = 1;
                        end else begin
                            m_col[i] = amax[i] - 1;
                            m_ovf[i] = 1;
                        end
                    end else begin
                        n = (m_pix[i] < amax[i]) ? m_pix[i] : amax[i];
                        if (m_len[i] != 0 && m_len[i] != n) m_lerr[i] = 1;
                        m_len[i] = n;
                        m_bank[i] = (m_bank[i] + 1) % 4;
                        if (m_lines[i] < 4095) m_lines[i]++;
                        if (m_filled[i] < 4) m_filled[i]++;
                        m_inline[i] = 0;
                        m_col[i] = 0;
                    end
                end else if (dv_rise) begin
                    m_inline[i] = 1; m_pix[i] = 1; m_col[i] = 0; m_wr[i] = 1;
                end
            end
        end
        m_hsq = rst ? 1'b0 : rx_hs;
        m_dvp = rst ? 1'b0 : rx_dv;
        m_vsp = rst ? 1'b0 : rx_vs;
    endtask

    function automatic logic [63:0] exp_vec(input int i);
        bit filt, first, last;
        filt  = m_wr[i] && (m_filled[i] == 4);
        first = m_wr[i] && (m_col[i] == 0);
        last  = m_wr[i] && (m_len[i] != 0) && (m_col[i] == m_len[i] - 1);
        return {8'd0, m_wr[i], 16'(m_col[i]), 4'(m_bank[i]), 16'(m_len[i]), 12'(m_lines[i]),
                m_fs[i], filt, first, last, m_lerr[i], m_ovf[i], m_hsq};
    endfunction

    function automatic logic [63:0] obs_vec(input int i);
        if (i == 0)
            return {8'd0, wr_en, 16'(col_addr), 4'(wr_bank), 16'(line_len), line_cnt,
                    frame_start, filt_valid, first_col, last_col, len_err, ovf, hs_q};
        return {8'd0, wr_en_s, 16'(col_addr_s), 4'(wr_bank_s), 16'(line_len_s), line_cnt_s,
                frame_start_s, filt_valid_s, first_col_s, last_col_s, len_err_s, ovf_s, hs_q_s};
    endfunction

    task automatic cycle(input bit dv, input bit vs, input bit r);
        @(negedge clk);
        rx_dv = dv;
        rx_vs = vs;
        rst   = r;
        rx_hs = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs_vec(i) !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_state[%0d]: got %h want 0", i, obs_vec(i));
            end
        end
        for (int c = 0; c < 12; c++) begin
            cycle(c[1], 0, 0);
            vectors++;
            if (wr_en !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_wr_en cyc %0d: got %b want 0", c, wr_en);
            end
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL idle[%0d] cyc %0d: got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_frame();
        int fs_cnt = 0;
        int filt_line = -1;
        int banks[$];
        int exp_banks[6] = '{0, 1, 2, 3, 0, 1};
        int last_cnt[6] = '{0, 0, 0, 0, 0, 0};
        cycle(0, 1, 0);
        if (frame_start) fs_cnt++;
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int l = 0; l < 6; l++) begin
            for (int p = 0; p < 12; p++) begin
                cycle(p < 8, 0, 0);
                if (frame_start) fs_cnt++;
                if (first_col) banks.push_back(int'(wr_bank));
                if (filt_valid && filt_line < 0) filt_line = l;
                if (last_col) begin
                    last_cnt[l]++;
                    vectors++;
                    if (col_addr !== 11'd7) begin
                        miscompares++;
                        $display("FAIL last_col_addr line %0d: got %0d want 7", l, col_addr);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    vectors++;
                    if (obs_vec(i) !== exp_vec(i)) begin
                        miscompares++;
                        $display("FAIL frame[%0d] line %0d px %0d: got %h want %h", i, l, p, obs_vec(i), exp_vec(i));
                    end
                end
            end
        end
        vectors++;
        if (fs_cnt !== 1) begin
            miscompares++;
            $display("FAIL frame_start_pulses: got %0d want 1", fs_cnt);
        end
        vectors++;
        if (banks.size() !== 6) begin
            miscompares++;
            $display("FAIL bank_seq_len: got %0d want 6", banks.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                vectors++;
                if (banks[k] !== exp_banks[k]) begin
                    miscompares++;
                    $display("FAIL bank_seq line %0d: got %0d want %0d", k, banks[k], exp_banks[k]);
                end
            end
        end
        vectors++;
        if (filt_line !== 4) begin
            miscompares++;
            $display("FAIL filt_valid_first_line: got %0d want 4", filt_line);
        end
        for (int l = 0; l < 6; l++) begin
            vectors++;
            if (last_cnt[l] !== ((l == 0) ? 0 : 1)) begin
                miscompares++;
                $display("FAIL last_col_count line %0d: got %0d want %0d", l, last_cnt[l], (l == 0) ? 0 : 1);
            end
        end
        vectors++;
        if (line_len !== 12'd8 || line_cnt !== 12'd6) begin
            miscompares++;
            $display("FAIL frame_totals: got len %0d cnt %0d want len 8 cnt 6", line_len, line_cnt);
        end
    endtask

    task automatic test_len_err();
        int lens[3] = '{8, 8, 9};
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < lens[l] + 4; p++) begin
                cycle(p < lens[l], 0, 0);
                if (p == lens[l] - 1 || p == lens[l]) begin
                    vectors++;
                    if (len_err !== ((l == 2 && p == lens[l]) ? 1'b1 : 1'b0)) begin
                        miscompares++;
                        $display("FAIL len_err line %0d px %0d: got %b", l, p, len_err);
                    end
                end
                for (int i = 0; i < 2; i++) begin
                    vectors++;
                    if (obs_vec(i) !== exp_vec(i)) begin
                        miscompares++;
                        $display("FAIL len_err_model[%0d] line %0d px %0d: got %h want %h", i, l, p, obs_vec(i), exp_vec(i));
                    end
                end
            end
        end
        vectors++;
        if (len_err !== 1'b1) begin
            miscompares++;
            $display("FAIL len_err_sticky: got %b want 1", len_err);
        end
        cycle(0, 1, 0);
        vectors++;
        if (len_err !== 1'b0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL len_err_clear: got err %b fs %b want err 0 fs 1", len_err, frame_start);
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_ovf();
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        for (int p = 0; p < 14; p++) begin
            cycle(p < 10, 0, 0);
            if (p < 8) begin
                vectors++;
                if (wr_en_s !== 1'b1 || col_addr_s !== 3'(p) || ovf_s !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_fill px %0d: got wr %b col %0d ovf %b want 1 %0d 0", p, wr_en_s, col_addr_s, ovf_s, p);
                end
            end else if (p < 10) begin
                vectors++;
                if (wr_en_s !== 1'b0 || col_addr_s !== 3'd7 || ovf_s !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovf_sat px %0d: got wr %b col %0d ovf %b want 0 7 1", p, wr_en_s, col_addr_s, ovf_s);
                end
            end
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL ovf_model[%0d] px %0d: got %h want %h", i, p, obs_vec(i), exp_vec(i));
                end
            end
        end
        vectors++;
        if (line_len_s !== 4'd8 || ovf_s !== 1'b1 || line_len !== 12'd10 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_result: got small len %0d ovf %b, big len %0d ovf %b want 8 1 10 0",
                     line_len_s, ovf_s, line_len, ovf);
        end
    endtask

    task automatic test_vs_abort();
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        vectors++;
        if (wr_en !== 1'b0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_edge: got wr %b fs %b want 0 1", wr_en, frame_start);
        end
        for (int c = 0; c < 3; c++) begin
            cycle(1, 0, 0);
            vectors++;
            if (wr_en !== 1'b0 || line_cnt !== 12'd0 || wr_bank !== 2'd0) begin
                miscompares++;
                $display("FAIL abort_hold cyc %0d: got wr %b cnt %0d bank %0d want 0 0 0", c, wr_en, line_cnt, wr_bank);
            end
        end
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int p = 0; p < 7; p++) begin
            cycle(p < 4, 0, 0);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL abort_model[%0d] px %0d: got %h want %h", i, p, obs_vec(i), exp_vec(i));
                end
            end
        end
        vectors++;
        if (line_cnt !== 12'd1 || wr_bank !== 2'd1) begin
            miscompares++;
            $display("FAIL abort_next_line: got cnt %0d bank %0d want 1 1", line_cnt, wr_bank);
        end
    endtask

    task automatic test_fall_vs_same();
        int fs_cnt = 0;
        cycle(0, 1, 0);
        if (frame_start) fs_cnt++;
        cycle(0, 0, 0);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 7; p++) begin
                cycle(p < 4, 0, 0);
                if (frame_start) fs_cnt++;
            end
        end
        vectors++;
        if (line_cnt !== 12'd2) begin
            miscompares++;
            $display("FAIL two_lines_cnt: got %0d want 2", line_cnt);
        end
        for (int p = 0; p < 4; p++) begin
            cycle(1, 0, 0);
            if (frame_start) fs_cnt++;
        end
        cycle(0, 1, 0);
        if (frame_start) fs_cnt++;
        vectors++;
        if (line_cnt !== 12'd0 || wr_bank !== 2'd0 || frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL fall_vs_same: got cnt %0d bank %0d fs %b want 0 0 1", line_cnt, wr_bank, frame_start);
        end
        cycle(0, 1, 0);
        if (frame_start) fs_cnt++;
        cycle(0, 0, 0);
        if (frame_start) fs_cnt++;
        vectors++;
        if (fs_cnt !== 2 || line_cnt !== 12'd0) begin
            miscompares++;
            $display("FAIL fall_vs_pulses: got fs %0d cnt %0d want 2 0", fs_cnt, line_cnt);
        end
    endtask

    task automatic test_reset_midline();
        cycle(0, 1, 0);
        cycle(0, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs_vec(i) !== 64'd0) begin
                miscompares++;
                $display("FAIL midline_reset[%0d]: got %h want 0", i, obs_vec(i));
            end
        end
        for (int c = 0; c < 8; c++) begin
            cycle(c != 3, 0, 0);
            vectors++;
            if (wr_en !== 1'b0 || wr_en_s !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle cyc %0d: got %b %b want 0 0", c, wr_en, wr_en_s);
            end
        end
    endtask

    task automatic test_random();
        int dv_left = 0;
        bit dv_lvl = 0;
        bit vs, r;
        for (int c = 0; c < 3000; c++) begin
            if (dv_left == 0) begin
                dv_lvl  = !dv_lvl;
                dv_left = dv_lvl ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 5));
            end
            dv_left--;
            vs = ($urandom_range(0, 59) == 0);
            r  = ($urandom_range(0, 699) == 0);
            cycle(dv_lvl, vs, r);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL random[%0d] cyc %0d: got %h want %h", i, c, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        rx_dv = 1'b0;
        rx_hs = 1'b0;
        rx_vs = 1'b0;
        test_reset();
        test_frame();
        test_len_err();
        test_ovf();
        test_vs_abort();
        test_fall_vs_same();
        test_reset_midline();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
Sequencing controller for the line-delay BRAM bank that feeds the 5-tap convolution cascade.
- Tracks frame and line timing from the incoming rx_dv/rx_vs stream.
- Generates the column address, write strobe and rotating bank pointer for the line buffers.
- Measures active line length and flags filter-valid and border conditions, so the datapath can start or mask taps correctly.
- Sits between the HDMI receiver outputs and the line-delay memory, in parallel with the pixel data path.

Parameters:
ADDR_W, 11, column address width; max supported line length is 2^ADDR_W pixels.
NUM_LINES, 4, number of line buffers in the delay bank (filter height minus 1).
LINE_W, 12, width of the per-frame line counter.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
rx_dv  in  1  data valid from receiver.
rx_hs  in  1  horizontal sync from receiver; not used for timing, passed to hs_q only.
rx_vs  in  1  vertical sync from receiver, active-high.
wr_en  out  1  line-buffer write strobe.
col_addr  out  ADDR_W  column address; shared read/write address, read-before-write.
wr_bank  out  log2(NUM_LINES)  index of the bank being written this line.
line_len  out  ADDR_W+1  pixel count of the last completed line.
line_cnt  out  LINE_W  completed lines in the current frame.
frame_start  out  1  one-cycle pulse on the rx_vs rising edge.
filt_valid  out  1  all NUM_LINES buffers hold lines of this frame and wr_en=1.
first_col  out  1  wr_en=1 and col_addr=0.
last_col  out  1  wr_en=1 and col_addr=line_len-1; forced 0 while line_len=0.
len_err  out  1  sticky: a completed line length differed from the previous one; cleared at frame start.
ovf  out  1  sticky: a line exceeded 2^ADDR_W pixels; cleared at frame start.
hs_q  out  1  rx_hs delayed 1 cycle, for alignment.

Behaviour:
- All outputs are registered. Latency from rx_dv/rx_vs to wr_en/col_addr/frame_start is 1 cycle.
- Reset values: every output is 0; FSM enters IDLE.
- Inputs are registered once internally (dv_q, vs_q). Edge detect uses the current input vs the registered value.
- FSM states:
  - IDLE: wait for the first rx_vs rising edge; wr_en is held 0 regardless of rx_dv. On rx_vs rise -> HBLANK.
  - HBLANK: on rx_dv rise -> ACTIVE.
  - ACTIVE: while rx_dv=1, col_addr increments by 1 per cycle starting at 0. On rx_dv fall -> HBLANK (line end).
- Line end:
  - line_len <= pixel count.
  - len_err is set if line_len was nonzero and differs from the new count.
  - col_addr <= 0.
  - wr_bank increments modulo NUM_LINES (wraps NUM_LINES-1 -> 0).
  - line_cnt increments, saturating at 2^LINE_W-1.
  - Internal lines_filled increments, saturating at NUM_LINES.
- filt_valid = (lines_filled==NUM_LINES) && wr_en.
- Overflow: if col_addr=2^ADDR_W-1 and rx_dv is still 1, col_addr holds, wr_en drops to 0 for the rest of the line, and ovf is set. line_len records 2^ADDR_W.
- Frame start (rx_vs rising edge, any state except reset):
  - frame_start pulses.
  - wr_bank, line_cnt, lines_filled, col_addr, len_err and ovf clear. line_len is retained.
  - State -> HBLANK.
- rx_vs rises while in ACTIVE: the line is aborted and not counted. wr_en drops the next cycle even if rx_dv stays 1; a fresh rx_dv rise is required to re-enter ACTIVE.
- rx_dv fall and rx_vs rise in the same cycle: the frame start wins and the line is not counted.
- rx_dv high for exactly 1 cycle: valid line, length 1, first_col and last_col both assert on the same cycle (once line_len=1 is known).
- rst asserted mid-line: takes effect on the next edge; all state clears and the FSM returns to IDLE.

Decomposition:
- Shared package video_pkg:
  - FSM state enum (IDLE, HBLANK, ACTIVE).
  - Constants for ADDR_W and NUM_LINES, shared with the line-delay bank and the DSP cascade.
  - The total pipeline-latency constant, used for sync-shift-register length.
- One natural sub-module, edge_det: 1-bit registered rise/fall detector, instantiated for dv and vs.
- Counters and FSM stay in line_buf_ctrl.

Test Plan:
- Reset, then rx_dv pulses with no rx_vs -> wr_en stays 0, FSM in IDLE, all outputs 0.
- rx_vs rise, then 6 lines of 8-pixel rx_dv, 4-cycle blank between lines -> frame_start 1 pulse; col_addr 0..7 per line; wr_bank sequence 0,1,2,3,0,1; line_len=8; filt_valid first high on line 5; last_col at col_addr 7 from line 2 onward.
- Lines of 8, 8, 9 pixels -> len_err rises 1 cycle after the third line ends and stays 1; next rx_vs rise clears it.
- ADDR_W=3 build, 10-pixel line -> col_addr saturates at 7, wr_en low for pixels 9-10, ovf=1, line_len=8.
- rx_vs rises at pixel 3 of a line with rx_dv still high -> wr_en 0 from the next cycle, line_cnt=0, wr_bank=0, no ACTIVE until the next rx_dv rise.
- rx_dv fall and rx_vs rise in the same cycle after 2 lines -> line_cnt reads 0 (not 3), frame_start pulses once.
